watchdog_multi: RTL

- Multi-channel, parametrised watchdog supervising NCH independent software/heartbeat sources.
- Each channel has its own timeout counter, a kick detector (wdg high then low, sampled on the shared pulso strobe), an optional early-kick window, and sticky or auto-restart fault handling.
- Sits between the monitored sources and the system fault/LED logic.
- fault_any gives a single summary line.

---
 rtl/watchdog_multi.sv | 128 ++++++++++++
 1 files changed

// File: rtl/watchdog_multi.sv
// ============================================================================
// Module   : watchdog_multi
// Purpose  : Multi-channel watchdog. Each of NCH channels runs its own timeout
//            counter and heartbeat kick detector. A kick is a high sample of
//            wdg followed later by a low sample, both taken only on pulso
//            strobes. An optional minimum window flags kicks that arrive too
//            early. Timeouts either auto-restart or latch until clr_err.
// Ports    : clk        - system clock, rising edge
//            reset      - asynchronous active-low reset
//            en[NCH]    - per-channel enable (0 = idle, flags cleared)
//            pulso      - shared sample strobe for wdg
//            wdg[NCH]   - per-channel heartbeat level
//            clr_err[NCH] - per-channel error clear, honoured only in FAULT
//            error[NCH] - registered per-channel fault flag
//            early[NCH] - registered per-channel early-kick flag
//            fault_any  - OR of all error bits
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module watchdog_multi #(
  parameter int NCH          = 4,
  parameter int CNT_W        = 28,
  parameter int TIMEOUT      = 251326592,
  parameter int WINDOW_MIN   = 0,
  parameter int AUTO_RESTART = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] en,
  input  logic           pulso,
  input  logic [NCH-1:0] wdg,
  input  logic [NCH-1:0] clr_err,
  output logic [NCH-1:0] error,
  output logic [NCH-1:0] early,
  output logic           fault_any
);

  typedef enum logic [1:0] {
    WAIT_HI = 2'd0,
    WAIT_LO = 2'd1,
    FAULT   = 2'd2
  } state_t;

  // Last count value before a timeout fires.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  // Highest count that still counts as an early kick. Expressed as "<=" so
  // the comparison stays meaningful (not constant) when the window is off.
  localparam bit               WIN_EN   = (WINDOW_MIN > 0);
  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'((WINDOW_MIN > 0) ? WINDOW_MIN - 1 : 0);
  localparam bit               AR_EN    = (AUTO_RESTART != 0);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_t           state_q;
    logic [CNT_W-1:0] count_q;
    logic             error_q;
    logic             early_q;
    logic             kick;
    logic             tmo;
    logic             too_soon;

    // A valid kick is the low sample that completes a high-then-low pair.
    assign kick     = pulso && (state_q == WAIT_LO) && !wdg[i];
    assign tmo      = (count_q == TMO_LAST);
    assign too_soon = WIN_EN && (count_q <= WIN_LAST);

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q <= WAIT_HI;
        count_q <= '0;
        error_q <= 1'b0;
        early_q <= 1'b0;
      end else if (!en[i]) begin
        state_q <= WAIT_HI;
        count_q <= '0;
        error_q <= 1'b0;
        early_q <= 1'b0;
      end else begin
        case (state_q)
          WAIT_HI, WAIT_LO: begin
            if (kick) begin
              // Kick beats a coincident timeout.
              count_q <= '0;
              if (too_soon) begin
                state_q <= FAULT;
                error_q <= 1'b1;
                early_q <= 1'b1;
              end else begin
                state_q <= WAIT_HI;
                error_q <= 1'b0;
                early_q <= 1'b0;
              end
            end else if (tmo) begin
              count_q <= '0;
              error_q <= 1'b1;
              state_q <= AR_EN ? WAIT_HI : FAULT;
            end else begin
              count_q <= count_q + CNT_W'(1);
              if (state_q == WAIT_HI && pulso && wdg[i]) begin
                state_q <= WAIT_LO;
              end
            end
          end
          FAULT: begin
            count_q <= '0;
            if (clr_err[i]) begin
              state_q <= WAIT_HI;
              error_q <= 1'b0;
              early_q <= 1'b0;
            end
          end
          default: begin
            state_q <= WAIT_HI;
            count_q <= '0;
          end
        endcase
      end
    end

    assign error[i] = error_q;
    assign early[i] = early_q;
  end

  assign fault_any = |error;

endmodule

`default_nettype wire
